seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
//
// PURPOSE
// - Scan scheduler for the 4-digit seven-segment display; drives the seg7decoder
//   inputs (select, nibble, dot) plus a per-digit enable.
// - Holds a 4-digit frame (nibble, dot and blank per digit) and steps through the
//   digits at a fixed slot rate.
// - Host writes a full frame through a valid/ready handshake. The frame is committed
//   only at a frame boundary, so the display never shows a mix of old and new digits.
//
// PARAMETERS
// - SLOT_CYCLES  100000  clock cycles per digit slot (1 kHz/digit at 100 MHz); >= 2
// - DIM_BITS     4       PWM resolution for dimming; used only with SEG7_DIM_EN
//
// PORTS
// - CLK100_IN    in   1         100 MHz clock
// - rst_n        in   1         reset, asynchronous, active-low
// - wr_valid     in   1         host frame-write request
// - wr_ready     out  1         block can accept a frame
// - wr_data      in   16        digit n nibble = wr_data[4n+3:4n]
// - wr_dots      in   4         digit n decimal point = wr_dots[n]
// - wr_blank     in   4         digit n blanked when wr_blank[n]=1
// - dim_level    in   DIM_BITS  brightness; port exists only with SEG7_DIM_EN
// - seg_select   out  2         digit select, to decoder SEG_SELECT_IN
// - bin          out  4         nibble, to decoder BIN_IN
// - dot          out  1         decimal point, to decoder DOT_IN
// - digit_en     out  1         1 = current digit lit; 0 = downstream forces segments off
// - frame_start  out  1         1-cycle pulse in the first cycle of each digit-0 slot
//
// BEHAVIOUR
// - Reset values (all flops asynchronous on rst_n low):
//   - seg_select=0, bin=0, dot=0, digit_en=0, frame_start=0, wr_ready=1
//   - active frame: data=0, dots=0, blank=4'hF (display dark until first commit)
// - Slot counter runs 0..SLOT_CYCLES-1, then wraps.
//   - At terminal count, seg_select advances modulo 4 (3 -> 0 wraps).
//   - The frame boundary is the terminal-count cycle while seg_select==3.
// - bin, dot and digit_en are registered.
//   - They follow active[next seg_select], so they change in the same cycle as
//     seg_select; there is no skew between select and data.
// - digit_en = ~active_blank[seg_select]. Dimming modifies this; see CONFIGURATION.
// - frame_start is high exactly in the cycle seg_select becomes 0.
// - Write FSM:
//   - IDLE (wr_ready=1): on wr_valid=1, capture wr_data/wr_dots/wr_blank into the
//     staging register and go to PENDING.
//   - PENDING (wr_ready=0): wr_valid is ignored. On the frame boundary, copy staging
//     to active (takes effect in the digit-0 slot that starts next cycle), then go
//     to IDLE.
// - Write accepted in the frame-boundary cycle itself:
//   - It is staged only; it commits at the following boundary.
//   - The frame starting next cycle still shows the old data.
// - Latency, accept to first visible digit: max 4*SLOT_CYCLES+1 cycles.
// - Reset mid-operation: staging is discarded and the active frame returns to blank.
//   No partial commit is possible.
// - Staging and active registers are 24 bits each. No arithmetic beyond the counters;
//   the slot counter width is $clog2(SLOT_CYCLES).
//
// CONFIGURATION
// - SEG7_DIM_EN defined:
//   - Adds the dim_level port and a DIM_BITS PWM counter. The counter resets to 0 at
//     each slot start and increments every cycle.
//   - digit_en = ~blank && (dim_level=='1 || pwm_cnt < dim_level).
//   - dim_level=0: always off. All-ones: always on.
// - SEG7_DIM_EN undefined: no dim_level port, no PWM counter; digit_en = ~blank.
//
// TESTING  (SLOT_CYCLES=4, DIM_BITS=4 unless noted)
// - Reset:
//   - Release rst_n: wr_ready=1, digit_en=0.
//   - seg_select steps 0,1,2,3,0 every 4 cycles.
//   - frame_start pulses every 16 cycles.
// - Basic write:
//   - Stimulus: wr_data=16'hCA80, wr_dots=4'b1010, wr_blank=0.
//   - After next frame_start: bin 0,8,A,C; dot 0,1,0,1; digit_en=1 in all slots.
// - Back-pressure:
//   - Stimulus: hold wr_valid with a second frame 16'h1234 while PENDING.
//   - wr_ready=0 until commit. Second write is accepted the cycle after commit and
//     becomes visible one frame after the first.
// - Boundary write:
//   - Stimulus: write 16'hFFFF in the frame-boundary cycle.
//   - Next frame shows old data; the frame after shows F,F,F,F.
// - Reset mid-PENDING:
//   - Stimulus: write, then pulse rst_n low before commit.
//   - Display stays blank (digit_en=0), wr_ready=1, the written data never appears.
// - SEG7_DIM_EN (SLOT_CYCLES=16):
//   - dim_level=4: digit_en high for 4 of 16 cycles per slot.
//   - dim_level=15: high for 16/16. dim_level=0: always low.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl_if
//   Frame-write handshake between a host and seg7_scan_ctrl.
//
//   wr_valid  host -> ctrl  frame-write request
//   wr_ready  ctrl -> host  controller can accept a frame
//   wr_data   host -> ctrl  digit n nibble = wr_data[4n+3:4n]
//   wr_dots   host -> ctrl  digit n decimal point = wr_dots[n]
//   wr_blank  host -> ctrl  digit n blanked when wr_blank[n] = 1
// -----------------------------------------------------------------------------
interface seg7_scan_ctrl_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dots;
  logic [3:0]  wr_blank;

  modport master (
    output wr_valid,
    output wr_data,
    output wr_dots,
    output wr_blank,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_dots,
    input  wr_blank,
    output wr_ready
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//   Scan scheduler for a 4-digit seven-segment display. Holds an active frame
//   (nibble, dot, blank per digit), steps through the digits at a fixed slot
//   rate and drives the decoder inputs. A host frame write is staged and only
//   committed at a frame boundary, so a displayed frame is never mixed.
//
//   Optional feature macro: SEG7_DIM_EN
//     defined   -> dim_level port plus a DIM_BITS PWM counter gating digit_en
//     undefined -> digit_en = ~blank of the current digit
//
// Ports
//   CLK100_IN    in   1         100 MHz clock
//   rst_n        in   1         asynchronous active-low reset
//   wr           slave modport  frame-write handshake (seg7_scan_ctrl_if)
//   dim_level    in   DIM_BITS  brightness (SEG7_DIM_EN only)
//   seg_select   out  2         digit select to decoder
//   bin          out  4         nibble to decoder
//   dot          out  1         decimal point to decoder
//   digit_en     out  1         1 = current digit lit
//   frame_start  out  1         pulse in the first cycle of each digit-0 slot
//
// Write FSM
//   state     | meaning
//   S_IDLE    | ready for a frame; wr_valid captures into staging
//   S_PENDING | staging full; waits for the frame boundary to commit
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int SLOT_CYCLES = 100000,
  parameter int DIM_BITS    = 4
) (
  input  logic                CLK100_IN,
  input  logic                rst_n,
  seg7_scan_ctrl_if.slave     wr,
`ifdef SEG7_DIM_EN
  input  logic [DIM_BITS-1:0] dim_level,
`endif
  output logic [1:0]          seg_select,
  output logic [3:0]          bin,
  output logic                dot,
  output logic                digit_en,
  output logic                frame_start
);

  localparam int                CNT_W     = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);

  if (SLOT_CYCLES < 2 || DIM_BITS < 1) begin : g_bad_param
    $error("seg7_scan_ctrl: SLOT_CYCLES must be >= 2 and DIM_BITS >= 1");
  end

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } wr_state_t;

  wr_state_t state_q;
  wr_state_t state_d;

  logic             capture;
  logic             commit;

  logic [CNT_W-1:0] slot_cnt;
  logic             slot_tc;
  logic             frame_bnd;
  logic [1:0]       sel_nxt;

  logic [3:0][3:0]  stg_data;
  logic [3:0]       stg_dots;
  logic [3:0]       stg_blank;

  logic [3:0][3:0]  act_data;
  logic [3:0]       act_dots;
  logic [3:0]       act_blank;

  logic [3:0][3:0]  act_data_nxt;
  logic [3:0]       act_dots_nxt;
  logic [3:0]       act_blank_nxt;

  logic             lit_nxt;

  // ---------------------------------------------------------------------------
  // Slot timing
  // ---------------------------------------------------------------------------
  assign slot_tc   = (slot_cnt == SLOT_LAST);
  assign frame_bnd = slot_tc && (seg_select == 2'd3);
  assign sel_nxt   = slot_tc ? seg_select + 2'd1 : seg_select;

  always_ff @(posedge CLK100_IN or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt    <= '0;
      seg_select  <= 2'd0;
      frame_start <= 1'b0;
    end else begin
      slot_cnt    <= slot_tc ? '0 : slot_cnt + CNT_W'(1);
      seg_select  <= sel_nxt;
      frame_start <= frame_bnd;
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK100_IN or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (wr.wr_valid) state_d = S_PENDING;
      S_PENDING: if (frame_bnd)   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // A capture in the boundary cycle happens in S_IDLE, so it cannot commit in
  // that same cycle; it waits for the next boundary.
  always_comb begin
    wr.wr_ready = 1'b0;
    capture     = 1'b0;
    commit      = 1'b0;
    case (state_q)
      S_IDLE: begin
        wr.wr_ready = 1'b1;
        capture     = wr.wr_valid;
      end
      S_PENDING: begin
        commit = frame_bnd;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Staging and active frames
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK100_IN or negedge rst_n) begin
    if (!rst_n) begin
      stg_data  <= '0;
      stg_dots  <= 4'h0;
      stg_blank <= 4'hF;
    end else if (capture) begin
      stg_data  <= wr.wr_data;
      stg_dots  <= wr.wr_dots;
      stg_blank <= wr.wr_blank;
    end
  end

  always_ff @(posedge CLK100_IN or negedge rst_n) begin
    if (!rst_n) begin
      act_data  <= '0;
      act_dots  <= 4'h0;
      act_blank <= 4'hF;
    end else if (commit) begin
      act_data  <= stg_data;
      act_dots  <= stg_dots;
      act_blank <= stg_blank;
    end
  end

  // Output registers look through the commit so the new frame is already on
  // bin/dot/digit_en in the first digit-0 cycle, aligned with seg_select.
  always_comb begin
    act_data_nxt  = commit ? stg_data  : act_data;
    act_dots_nxt  = commit ? stg_dots  : act_dots;
    act_blank_nxt = commit ? stg_blank : act_blank;
  end

  // ---------------------------------------------------------------------------
  // Digit enable (optional PWM dimming)
  // ---------------------------------------------------------------------------
`ifdef SEG7_DIM_EN
  logic [DIM_BITS-1:0] pwm_cnt;
  logic [DIM_BITS-1:0] pwm_nxt;

  // pwm_cnt tracks the position inside the slot (mod 2^DIM_BITS), restarting
  // at 0 with every slot.
  assign pwm_nxt = slot_tc ? '0 : pwm_cnt + DIM_BITS'(1);

  always_ff @(posedge CLK100_IN or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_nxt;
    end
  end

  always_comb begin
    lit_nxt = ~act_blank_nxt[sel_nxt] &&
              ((dim_level == '1) || (pwm_nxt < dim_level));
  end
`else
  always_comb begin
    lit_nxt = ~act_blank_nxt[sel_nxt];
  end
`endif

  // ---------------------------------------------------------------------------
  // Decoder outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK100_IN or negedge rst_n) begin
    if (!rst_n) begin
      bin      <= 4'h0;
      dot      <= 1'b0;
      digit_en <= 1'b0;
    end else begin
      bin      <= act_data_nxt[sel_nxt];
      dot      <= act_dots_nxt[sel_nxt];
      digit_en <= lit_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//   Bench for seg7_scan_ctrl. Accepted frames are pushed to a queue tagged with
//   the frame number where they must first appear; a negedge monitor pops them
//   at that frame and compares every output against the expected frame and a
//   cycle-count model of the scan position.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

`ifdef SEG7_DIM_EN
  localparam int SLOT = 16;
`else
  localparam int SLOT = 4;
`endif
  localparam int FRAME    = 4 * SLOT;
  localparam int DIM_BITS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] seg_select;
  logic [3:0] bin;
  logic       dot;
  logic       digit_en;
  logic       frame_start;
`ifdef SEG7_DIM_EN
  logic [DIM_BITS-1:0] dim_level = '1;
  logic [DIM_BITS-1:0] dim_q = '1;
`endif

  seg7_scan_ctrl_if wr ();

  seg7_scan_ctrl #(
    .SLOT_CYCLES (SLOT),
    .DIM_BITS    (DIM_BITS)
  ) dut (
    .CLK100_IN   (clk),
    .rst_n       (rst_n),
    .wr          (wr),
`ifdef SEG7_DIM_EN
    .dim_level   (dim_level),
`endif
    .seg_select  (seg_select),
    .bin         (bin),
    .dot         (dot),
    .digit_en    (digit_en),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dots;
    logic [3:0]  blank;
    int          frame_no;
  } frame_t;

  frame_t exp_q[$];
  frame_t shown;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Cycle index since reset release; equals the slot-counter model position.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

`ifdef SEG7_DIM_EN
  always @(posedge clk) dim_q <= dim_level;
`endif

  int         sel_e;
  logic       fs_e;
  logic       en_e;
  logic [3:0] bin_e;
`ifdef SEG7_DIM_EN
  int         pwm_e;
`endif

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      shown = '{data: 16'h0, dots: 4'h0, blank: 4'hF, frame_no: 0};
    end else begin
      while (exp_q.size() > 0 && exp_q[0].frame_no <= cyc / FRAME)
        shown = exp_q.pop_front();
    end
    sel_e = (cyc / SLOT) % 4;
    fs_e  = (cyc > 0) && (cyc % FRAME == 0);
    bin_e = shown.data[sel_e*4 +: 4];
    en_e  = !shown.blank[sel_e];
`ifdef SEG7_DIM_EN
    pwm_e = (cyc % SLOT) % (1 << DIM_BITS);
    en_e  = en_e && ((dim_q == '1) || (pwm_e < int'(dim_q)));
`endif
    check_eq("seg_select",  seg_select,  sel_e[1:0]);
    check_eq("frame_start", frame_start, fs_e);
    check_eq("bin",         bin,         bin_e);
    check_eq("dot",         dot,         shown.dots[sel_e]);
    check_eq("digit_en",    digit_en,    en_e);
    check_eq("wr_ready",    wr.wr_ready, exp_q.size() == 0);
    // A frame accepted in cycle c commits at the first boundary after c and
    // is visible from the frame that starts right after that boundary.
    if (rst_n && wr.wr_valid && wr.wr_ready)
      exp_q.push_back('{data: wr.wr_data, dots: wr.wr_dots, blank: wr.wr_blank,
                        frame_no: (cyc + 1) / FRAME + 1});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; holds wr_valid until a handshake is seen.
  task automatic write_frame(input logic [15:0] d, input logic [3:0] dt, input logic [3:0] bl);
    logic acc;
    acc         = 1'b0;
    wr.wr_valid = 1'b1;
    wr.wr_data  = d;
    wr.wr_dots  = dt;
    wr.wr_blank = bl;
    for (int i = 0; i < 8 * FRAME && !acc; i++) begin
      @(negedge clk);
      acc = wr.wr_ready;
      @(posedge clk);
      #1;
    end
    wr.wr_valid = 1'b0;
    check_eq("write_accept", acc, 1'b1);
  endtask

  task automatic align(input int ph);
    for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != ph; i++) tick(1);
    check_eq("align", cyc % FRAME, ph);
  endtask

  initial begin
    wr.wr_valid = 1'b0;
    wr.wr_data  = 16'h0;
    wr.wr_dots  = 4'h0;
    wr.wr_blank = 4'h0;
    #2 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;

    // idle scan after reset: dark display, select stepping, frame pulses
    tick(2 * FRAME + 3);

    // basic write
    write_frame(16'hCA80, 4'b1010, 4'b0000);
    tick(3 * FRAME);

    // back-pressure: second frame held while the first is pending
    write_frame(16'h5678, 4'b0101, 4'b0010);
    write_frame(16'h1234, 4'b0011, 4'b0000);
    tick(3 * FRAME);

    // write in the frame-boundary cycle itself
    align(FRAME - 1);
    write_frame(16'hFFFF, 4'b0000, 4'b0000);
    tick(3 * FRAME);

    // reset while a frame is pending
    align(2);
    write_frame(16'h9999, 4'b1111, 4'b0000);
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2 * FRAME);
    check_eq("rst_ready_after", wr.wr_ready, 1'b1);
    check_eq("rst_dark_after",  digit_en,    1'b0);

`ifdef SEG7_DIM_EN
    write_frame(16'h4321, 4'b0000, 4'b0000);
    tick(2 * FRAME);
    dim_level = 4'd4;
    tick(FRAME);
    dim_level = 4'd15;
    tick(FRAME);
    dim_level = 4'd0;
    tick(FRAME);
    dim_level = 4'd9;
    tick(FRAME);
`endif

    check_eq("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
